// File: rtl/full_add_checker.sv
// -----------------------------------------------------------------------------
// full_add_checker
//
// Response checker for a 1-bit full adder. Each cycle with vld high during a
// run, the applied stimulus {a,b,cin} and the adder's response {sum,cout} are
// compared against a golden full-adder model. The block counts accepted
// vectors and mismatches, captures the first failing vector, tracks which of
// the eight input combinations have been seen, and reports pass/fail once
// NUM_VECTORS vectors have been checked.
//
// Handshake: there is no back-pressure. A vector is accepted on every rising
// edge where the FSM is in RUN and vld is high; vld outside RUN is dropped.
// start is a one-cycle pulse honoured only in IDLE or DONE.
//
// Ports
//   clk        in   sampling clock, rising edge active
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a run (ignored while busy)
//   vld        in   a/b/cin/sum/cout carry a vector this cycle
//   a,b,cin    in   stimulus applied to the adder
//   sum,cout   in   adder response
//   busy       out  FSM in RUN
//   done       out  FSM in DONE
//   pass       out  done with no mismatches
//   vec_cnt    out  vectors accepted in this run
//   err_cnt    out  mismatching vectors, saturating
//   fail_seen  out  at least one mismatch this run
//   fail_idx   out  vec_cnt value of the first failing vector
//   fail_vec   out  first failing vector {a,b,cin,sum,cout}
//   cov        out  bit {a,b,cin} set once that combination was accepted
//   all_cov    out  every combination seen
//   dbg_state  out  raw FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module full_add_checker #(
  parameter int CNT_W       = 8,
  parameter int NUM_VECTORS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vld,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail_seen,
  output logic [CNT_W-1:0] fail_idx,
  output logic [4:0]       fail_vec,
  output logic [7:0]       cov,
  output logic             all_cov,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Value of vec_cnt while the final vector of a run is being accepted.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_vec_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_fail_seen;
  logic [CNT_W-1:0] r_fail_idx;
  logic [4:0]       r_fail_vec;
  logic [7:0]       r_cov;

  logic       w_exp_sum;
  logic       w_exp_cout;
  logic       w_mismatch;
  logic       w_accept;
  logic       w_clear;
  logic       w_last;
  logic [2:0] w_cov_idx;

  // Golden full-adder model.
  assign w_exp_sum  = a ^ b ^ cin;
  assign w_exp_cout = (a & b) | (a & cin) | (b & cin);
  assign w_mismatch = (sum != w_exp_sum) || (cout != w_exp_cout);

  assign w_accept  = (r_state == ST_RUN) && vld;
  // A start that launches a run wipes the previous results on the same edge;
  // a vector presented alongside it is not accepted because state is not RUN.
  assign w_clear   = start && (r_state != ST_RUN);
  assign w_last    = w_accept && (r_vec_cnt == LAST_IDX);
  assign w_cov_idx = {a, b, cin};

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: if (start)  w_state_nxt = ST_RUN;
      default:             w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters, first-failure capture and coverage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec_cnt   <= '0;
      r_err_cnt   <= '0;
      r_fail_seen <= 1'b0;
      r_fail_idx  <= '0;
      r_fail_vec  <= '0;
      r_cov       <= '0;
    end else if (w_clear) begin
      r_vec_cnt   <= '0;
      r_err_cnt   <= '0;
      r_fail_seen <= 1'b0;
      r_fail_idx  <= '0;
      r_fail_vec  <= '0;
      r_cov       <= '0;
    end else if (w_accept) begin
      r_vec_cnt        <= r_vec_cnt + 1'b1;
      r_cov[w_cov_idx] <= 1'b1;
      if (w_mismatch) begin
        // Hold at all-ones rather than wrapping back to a clean-looking zero.
        if (r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + 1'b1;
        end
        if (!r_fail_seen) begin
          r_fail_seen <= 1'b1;
          r_fail_idx  <= r_vec_cnt;
          r_fail_vec  <= {a, b, cin, sum, cout};
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registered state
  // ---------------------------------------------------------------------------
  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign pass      = done && (r_err_cnt == '0);
  assign vec_cnt   = r_vec_cnt;
  assign err_cnt   = r_err_cnt;
  assign fail_seen = r_fail_seen;
  assign fail_idx  = r_fail_idx;
  assign fail_vec  = r_fail_vec;
  assign cov       = r_cov;
  assign all_cov   = (r_cov == 8'hFF);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_full_add_checker.sv
module tb_full_add_checker;

  logic clk;
  logic rst_n;
  logic start;
  logic vld;
  logic a, b, cin, sum, cout;

  // Main instance: CNT_W=8, NUM_VECTORS=8
  logic       busy, done, pass, fail_seen, all_cov;
  logic [7:0] vec_cnt, err_cnt, fail_idx, cov;
  logic [4:0] fail_vec;
  logic [1:0] dbg_state;

  // Saturation instance: CNT_W=3, NUM_VECTORS=7
  logic       s_busy, s_done, s_pass, s_fail_seen, s_all_cov;
  logic [2:0] s_vec_cnt, s_err_cnt, s_fail_idx;
  logic [7:0] s_cov;
  logic [4:0] s_fail_vec;
  logic [1:0] s_dbg_state;

  int n_checks;
  int n_fail;

  // Hand-computed full-adder truth table, indexed by {a,b,cin}.
  logic [7:0] sum_tbl;
  logic [7:0] cout_tbl;

  full_add_checker #(.CNT_W(8), .NUM_VECTORS(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vld(vld),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .busy(busy), .done(done), .pass(pass),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt), .fail_seen(fail_seen),
    .fail_idx(fail_idx), .fail_vec(fail_vec), .cov(cov),
    .all_cov(all_cov), .dbg_state(dbg_state)
  );

  full_add_checker #(.CNT_W(3), .NUM_VECTORS(7)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .vld(vld),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .busy(s_busy), .done(s_done), .pass(s_pass),
    .vec_cnt(s_vec_cnt), .err_cnt(s_err_cnt), .fail_seen(s_fail_seen),
    .fail_idx(s_fail_idx), .fail_vec(s_fail_vec), .cov(s_cov),
    .all_cov(s_all_cov), .dbg_state(s_dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    vld   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Drivers (inputs change 1 time unit after the rising edge; outputs are
  // sampled at that same point, i.e. just after the accepting edge)
  // ---------------------------------------------------------------------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drive_vec(input logic [2:0] abc, input logic s, input logic c);
    {a, b, cin} = abc;
    sum  = s;
    cout = c;
    vld  = 1'b1;
    @(posedge clk);
    #1;
    vld  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    n_checks++; if ({busy, done, pass, fail_seen, all_cov} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, pass, fail_seen, all_cov}); end
    n_checks++; if ({vec_cnt, err_cnt, fail_idx, cov} !== 32'h0) begin n_fail++; $display("FAIL reset_counts: got %h expected 0", {vec_cnt, err_cnt, fail_idx, cov}); end
    n_checks++; if (fail_vec !== 5'b0) begin n_fail++; $display("FAIL reset_fail_vec: got %b expected 00000", fail_vec); end
    n_checks++; if ({s_busy, s_done, s_vec_cnt, s_err_cnt} !== 8'h0) begin n_fail++; $display("FAIL reset_sat: got %h expected 0", {s_busy, s_done, s_vec_cnt, s_err_cnt}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_hold: busy got %b expected 0", busy); end
  endtask

  task automatic test_exhaustive();
    pulse_start();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL exh_busy_after_start: got %b expected 1", busy); end
    n_checks++; if (vec_cnt !== 8'd0) begin n_fail++; $display("FAIL exh_vec_cnt_start: got %0d expected 0", vec_cnt); end
    for (int i = 0; i < 8; i++) begin
      drive_vec(3'(i), sum_tbl[i], cout_tbl[i]);
      if (i == 0) begin
        n_checks++; if (vec_cnt !== 8'd1 || cov !== 8'h01) begin n_fail++; $display("FAIL exh_first_latency: vec_cnt %0d cov %h expected 1 01", vec_cnt, cov); end
      end
      if (i == 6) begin
        n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL exh_not_done_at_7: done %b busy %b expected 0 1", done, busy); end
      end
    end
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL exh_done: done %b busy %b expected 1 0", done, busy); end
    n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL exh_pass: got %b expected 1", pass); end
    n_checks++; if (vec_cnt !== 8'd8) begin n_fail++; $display("FAIL exh_vec_cnt: got %0d expected 8", vec_cnt); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL exh_err_cnt: got %0d expected 0", err_cnt); end
    n_checks++; if (cov !== 8'hFF || all_cov !== 1'b1) begin n_fail++; $display("FAIL exh_cov: cov %h all_cov %b expected ff 1", cov, all_cov); end
    n_checks++; if (fail_seen !== 1'b0) begin n_fail++; $display("FAIL exh_fail_seen: got %b expected 0", fail_seen); end
    idle_cycle();
    n_checks++; if (pass !== 1'b1 || done !== 1'b1) begin n_fail++; $display("FAIL exh_hold: pass %b done %b expected 1 1", pass, done); end
  endtask

  // Starts from DONE of the previous run: also checks that results clear.
  task automatic test_fault();
    pulse_start();
    n_checks++; if (busy !== 1'b1 || cov !== 8'h00 || vec_cnt !== 8'd0) begin n_fail++; $display("FAIL fault_clear: busy %b cov %h vec_cnt %0d expected 1 00 0", busy, cov, vec_cnt); end
    for (int i = 0; i < 8; i++) begin
      if (i == 3) drive_vec(3'b011, 1'b1, 1'b1);
      else        drive_vec(3'(i), sum_tbl[i], cout_tbl[i]);
    end
    n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL fault_err_cnt: got %0d expected 1", err_cnt); end
    n_checks++; if (fail_seen !== 1'b1) begin n_fail++; $display("FAIL fault_fail_seen: got %b expected 1", fail_seen); end
    n_checks++; if (fail_idx !== 8'd3) begin n_fail++; $display("FAIL fault_fail_idx: got %0d expected 3", fail_idx); end
    n_checks++; if (fail_vec !== 5'b01111) begin n_fail++; $display("FAIL fault_fail_vec: got %b expected 01111", fail_vec); end
    n_checks++; if (done !== 1'b1 || pass !== 1'b0) begin n_fail++; $display("FAIL fault_pass: done %b pass %b expected 1 0", done, pass); end
  endtask

  task automatic test_gapped();
    do_reset();
    // vld while IDLE must be dropped
    drive_vec(3'b000, 1'b0, 1'b0);
    drive_vec(3'b101, 1'b0, 1'b1);
    n_checks++; if (vec_cnt !== 8'd0 || cov !== 8'h00) begin n_fail++; $display("FAIL gap_idle_vld: vec_cnt %0d cov %h expected 0 00", vec_cnt, cov); end
    // start with vld in the same cycle: run begins, vector not accepted
    {a, b, cin, sum, cout} = 5'b00000;
    vld = 1'b1;
    pulse_start();
    vld = 1'b0;
    n_checks++; if (busy !== 1'b1 || vec_cnt !== 8'd0) begin n_fail++; $display("FAIL gap_start_vld: busy %b vec_cnt %0d expected 1 0", busy, vec_cnt); end
    for (int i = 0; i < 8; i++) begin
      drive_vec(3'b000, 1'b0, 1'b0);
      repeat (1 + (i % 3)) idle_cycle();
    end
    n_checks++; if (vec_cnt !== 8'd8 || done !== 1'b1) begin n_fail++; $display("FAIL gap_vec_cnt: vec_cnt %0d done %b expected 8 1", vec_cnt, done); end
    n_checks++; if (cov !== 8'h01 || all_cov !== 1'b0) begin n_fail++; $display("FAIL gap_cov: cov %h all_cov %b expected 01 0", cov, all_cov); end
    n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL gap_pass: got %b expected 1", pass); end
    // vld while DONE must be dropped
    drive_vec(3'b110, 1'b1, 1'b1);
    n_checks++; if (vec_cnt !== 8'd8 || err_cnt !== 8'd0 || cov !== 8'h01) begin n_fail++; $display("FAIL gap_done_vld: vec_cnt %0d err %0d cov %h expected 8 0 01", vec_cnt, err_cnt, cov); end
  endtask

  task automatic test_restart_ignore_start();
    pulse_start();
    for (int i = 0; i < 4; i++) drive_vec(3'(i), sum_tbl[i], cout_tbl[i]);
    pulse_start();
    n_checks++; if (busy !== 1'b1 || vec_cnt !== 8'd4) begin n_fail++; $display("FAIL rs_start_in_run: busy %b vec_cnt %0d expected 1 4", busy, vec_cnt); end
    for (int i = 4; i < 8; i++) drive_vec(3'(i), sum_tbl[i], cout_tbl[i]);
    n_checks++; if (done !== 1'b1 || vec_cnt !== 8'd8 || pass !== 1'b1) begin n_fail++; $display("FAIL rs_done: done %b vec_cnt %0d pass %b expected 1 8 1", done, vec_cnt, pass); end
  endtask

  task automatic test_reset_midrun();
    pulse_start();
    drive_vec(3'b000, 1'b0, 1'b0);
    drive_vec(3'b001, 1'b0, 1'b0);   // wrong: expected sum=1
    drive_vec(3'b010, 1'b1, 1'b0);
    drive_vec(3'b011, 1'b0, 1'b1);
    n_checks++; if (vec_cnt !== 8'd4 || fail_seen !== 1'b1 || fail_idx !== 8'd1 || fail_vec !== 5'b00100) begin n_fail++; $display("FAIL mid_before: vec_cnt %0d fail_seen %b idx %0d vec %b expected 4 1 1 00100", vec_cnt, fail_seen, fail_idx, fail_vec); end
    #2;
    rst_n = 1'b0;   // between edges: must act without a clock
    #1;
    n_checks++; if (dbg_state !== 2'd0 || {busy, done, pass, fail_seen, all_cov} !== 5'b0) begin n_fail++; $display("FAIL mid_reset_flags: state %0d flags %b expected 0 00000", dbg_state, {busy, done, pass, fail_seen, all_cov}); end
    n_checks++; if ({vec_cnt, err_cnt, fail_idx, cov} !== 32'h0 || fail_vec !== 5'b0) begin n_fail++; $display("FAIL mid_reset_counts: got %h %b expected 0 0", {vec_cnt, err_cnt, fail_idx, cov}, fail_vec); end
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();
  endtask

  task automatic test_saturation();
    do_reset();
    pulse_start();
    for (int i = 0; i < 7; i++) drive_vec(3'(i), ~sum_tbl[i], cout_tbl[i]);
    n_checks++; if (s_err_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_err_cnt: got %0d expected 7", s_err_cnt); end
    n_checks++; if (s_done !== 1'b1 || s_pass !== 1'b0 || s_vec_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_done: done %b pass %b vec_cnt %0d expected 1 0 7", s_done, s_pass, s_vec_cnt); end
    n_checks++; if (s_fail_idx !== 3'd0 || s_fail_vec !== 5'b00010) begin n_fail++; $display("FAIL sat_first: idx %0d vec %b expected 0 00010", s_fail_idx, s_fail_vec); end
    drive_vec(3'b111, 1'b0, 1'b0);
    n_checks++; if (s_err_cnt !== 3'd7 || s_vec_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_hold: err %0d vec %0d expected 7 7", s_err_cnt, s_vec_cnt); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    sum_tbl  = 8'b1001_0110;
    cout_tbl = 8'b1110_1000;
    rst_n = 1'b0;
    start = 1'b0;
    vld   = 1'b0;
    {a, b, cin, sum, cout} = 5'b0;
    repeat (2) @(posedge clk);

    test_reset();
    test_exhaustive();
    test_fault();
    test_gapped();
    test_restart_ignore_start();
    test_reset_midrun();
    test_saturation();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
